fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the single combinational read port of the instruction memory.
- Buffers fetched words in a small prefetch FIFO and hands them to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects (with flush) and halt.
- Sits between the instruction memory and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, prefetch FIFO entries (power of 2, ≥2).
- CNT_W, 32, width of the accepted-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  level; 0 holds the sequencer in IDLE.
- Halt  in  1  level; stops new fetches while high.
- Redirect  in  1  single-cycle pulse: load RedirectPC and flush.
- RedirectPC  in  32  target PC; bits [1:0] ignored.
- ImemAddr  out  32  address to instruction memory, always {PC[31:2],2'b00}.
- ImemData  in  32  instruction word; combinational, valid same cycle as ImemAddr.
- InstrValid  out  1  FIFO head holds a valid instruction.
- InstrReady  in  1  decode accepts the head this cycle.
- Instr  out  32  head instruction word.
- InstrPC  out  32  PC of head instruction.
- InstrPCPlus4  out  32  InstrPC + 4, modulo 2^32.
- Busy  out  1  state == RUN.
- AcceptCount  out  CNT_W  count of valid&ready handshakes.

Behaviour:
- Reset (async, Reset=0):
  - PC=RESET_PC, state=IDLE, FIFO empty.
  - InstrValid=0, Instr=0, InstrPC=0, InstrPCPlus4=4, Busy=0, AcceptCount=0.
- States:
  - IDLE: Enable=1 -> RUN.
  - RUN: Halt=1 and no Redirect -> HALTED; Enable=0 -> IDLE.
  - HALTED: Halt=0 -> RUN; Enable=0 -> IDLE.
  - Redirect is legal in every state; it does not change state.
- Fetch:
  - A fetch occurs in a cycle when state==RUN, Halt=0, Redirect=0, and the FIFO is either not full or full with pop=InstrValid&InstrReady in the same cycle.
  - On fetch, {PC, ImemData} is pushed and PC<=PC+4 (wraps 32'hFFFF_FFFC -> 0).
  - Sustained throughput is 1 instruction/cycle.
- Latency: the word fetched in cycle N appears at the FIFO head (InstrValid=1) in cycle N+1 if the FIFO was empty.
- Handshake:
  - The head is stable while InstrValid=1 and InstrReady=0.
  - Pop happens only on InstrValid&InstrReady.
  - InstrReady while InstrValid=0 is ignored.
- Redirect (highest priority):
  - FIFO cleared, PC<={RedirectPC[31:2],2'b00}, no push and no pop-count that cycle.
  - InstrValid=0 in the next cycle.
  - Target is fetched in the next cycle and valid the cycle after.
  - A handshake coinciding with Redirect is discarded and not counted.
- Full FIFO with no pop: no fetch, PC held, ImemAddr held.
- Empty FIFO with InstrReady=1: no effect.
- Halt / Enable=0 stop fetching only; the FIFO continues to drain. Enable=0 also holds PC.
- AcceptCount increments on every counted handshake and wraps at 2^CNT_W.
- Reset mid-operation: immediate asynchronous return to the reset values above; in-flight entries are lost.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, HALTED}, 2 bits.
  - RESET_PC default.
  - INSTR_NOP = 32'h0000_0000.
  - Entry struct {pc[31:0], word[31:0]}.
- Sub-module fetch_fifo: generic synchronous FIFO.
  - Parameters DEPTH and width.
  - Ports push, pop, flush, full, empty, head.
  - Flush has priority over push/pop.

Test Plan:
- Reset release, Enable=1, InstrReady=1, memory[i]=i*3:
  - Head sequence PC 0,4,8 with Instr 0,3,6.
  - First InstrValid 1 cycle after entering RUN.
  - AcceptCount=3 after 3 handshakes.
- InstrReady=0 for 5 cycles, then 1:
  - Exactly DEPTH entries fetched, ImemAddr frozen at 4*DEPTH.
  - Head held stable; no words lost or duplicated after release.
- Redirect to 32'h0000_0043 with a full FIFO:
  - Next cycle InstrValid=0.
  - Following cycle Instr=memory[16], InstrPC=0x40.
  - Stale entries never appear.
- Halt=1 for 4 cycles with InstrReady=1:
  - FIFO drains, ImemAddr constant, Busy=0.
  - Halt=0 resumes at the held PC.
- RESET_PC=32'hFFFF_FFF8, run 3 fetches: InstrPC 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset asserted mid-stream with the FIFO half full: outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch
//               sequencer: FSM state encoding, prefetch FIFO entry layout,
//               default reset PC and the NOP word shown on an empty head.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Generic synchronous FIFO used as the prefetch buffer.
//               Head is read combinationally; flush empties the FIFO and
//               wins over push/pop in the same cycle. A push into a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Ports       : clk_i   - clock, rising edge
//               rst_ni  - asynchronous active-low reset (empties the FIFO)
//               push_i  - write data_i at the tail
//               pop_i   - drop the head entry (ignored when empty)
//               flush_i - discard all entries
//               data_i  - tail write data
//               full_o  - all DEPTH entries occupied
//               empty_o - no entries occupied
//               head_o  - oldest entry (undefined content when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int              c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[c_PTR_W] != rd_ptr_q[c_PTR_W]) &&
                   (wr_ptr_q[c_PTR_W-1:0] == rd_ptr_q[c_PTR_W-1:0]);

  assign w_do_pop  = pop_i & ~empty_o;
  // When full, the slot being written is the one being popped this cycle.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  assign head_o = mem_q[rd_ptr_q[c_PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (!flush_i && w_do_push) begin
      mem_q[wr_ptr_q[c_PTR_W-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the program counter, drives the combinational
//               instruction memory read port, buffers fetched words in a
//               prefetch FIFO and hands them to decode via valid/ready.
//               Supports halt, enable, and redirect with flush.
// Ports       : clk_i            - clock, rising edge
//               rst_ni           - asynchronous active-low reset
//               enable_i         - 0 holds the sequencer in IDLE
//               halt_i           - stops new fetches while high
//               redirect_i       - pulse: load redirect_pc_i, flush FIFO
//               redirect_pc_i    - redirect target (bits [1:0] ignored)
//               imem_addr_o      - word-aligned instruction memory address
//               imem_data_i      - instruction word for imem_addr_o
//               instr_valid_o    - FIFO head holds an instruction
//               instr_ready_i    - decode accepts the head this cycle
//               instr_o          - head instruction word
//               instr_pc_o       - PC of head instruction
//               instr_pc_plus4_o - instr_pc_o + 4
//               busy_o           - sequencer is in RUN
//               accept_count_o   - number of accepted handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             halt_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      instr_pc_o,
  output logic [31:0]      instr_pc_plus4_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] accept_count_o
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             w_full;
  logic             w_empty;
  logic             w_handshake;
  logic             w_fetch;
  entry_t           w_push_entry;
  entry_t           w_head;

  // --------------------------------------------------------------------------
  // Control FSM. Enable=0 dominates; a redirect keeps RUN from entering HALTED
  // so that the redirect target can be fetched once halt drops.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        if (!enable_i)                     state_d = IDLE;
        else if (halt_i && !redirect_i)    state_d = HALTED;
      end
      HALTED: begin
        if (!enable_i)      state_d = IDLE;
        else if (!halt_i)   state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch / handshake. A handshake coinciding with a redirect is discarded,
  // so it neither pops nor counts (the flush clears the FIFO anyway).
  // --------------------------------------------------------------------------
  assign w_handshake = ~w_empty & instr_ready_i & ~redirect_i;
  assign w_fetch     = (state_q == RUN) & enable_i & ~halt_i & ~redirect_i &
                       (~w_full | w_handshake);

  assign w_push_entry.pc   = pc_q;
  assign w_push_entry.word = imem_data_i;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (w_fetch) begin
      pc_d = pc_q + PC_STEP;
    end
    if (w_handshake) begin
      count_d = count_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= align_pc(RESET_PC);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_fetch),
    .pop_i   (w_handshake),
    .flush_i (redirect_i),
    .data_i  (w_push_entry),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // --------------------------------------------------------------------------
  // Outputs. An empty head is presented as NOP at PC 0 so the decode-facing
  // signals have defined values straight out of reset.
  // --------------------------------------------------------------------------
  assign imem_addr_o      = pc_q;
  assign instr_valid_o    = ~w_empty;
  assign instr_o          = w_empty ? INSTR_NOP : w_head.word;
  assign instr_pc_o       = w_empty ? 32'h0000_0000 : w_head.pc;
  assign instr_pc_plus4_o = instr_pc_o + PC_STEP;
  assign busy_o           = (state_q == RUN);
  assign accept_count_o   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A queue-based model
//               of the prefetch behaviour is compared with the DUT every
//               cycle; directed phases pin literal values, and a second
//               instance checks PC wrap from a high reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int c_DEPTH  = 2;
  localparam int c_S_IDLE = 0;
  localparam int c_S_RUN  = 1;
  localparam int c_S_HALT = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        halt  = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc   = 32'h0;
  logic        ready = 1'b0;

  logic        en1    = 1'b0;
  logic        zero1  = 1'b0;
  logic        ready1 = 1'b1;

  wire logic [31:0] addr0, data0, instr0, ipc0, ip40, cnt0;
  wire logic        valid0, busy0;
  wire logic [31:0] addr1, data1, instr1, ipc1, ip41, cnt1;
  wire logic        valid1, busy1;

  // Instruction memory image: word i holds i*3.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) * 32'd3;
  endfunction

  assign data0 = mem(addr0);
  assign data1 = mem(addr1);

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(c_DEPTH), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .halt_i(halt),
    .redirect_i(redir), .redirect_pc_i(rpc), .imem_addr_o(addr0),
    .imem_data_i(data0), .instr_valid_o(valid0), .instr_ready_i(ready),
    .instr_o(instr0), .instr_pc_o(ipc0), .instr_pc_plus4_o(ip40),
    .busy_o(busy0), .accept_count_o(cnt0)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(c_DEPTH), .CNT_W(32)) dut_hi (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en1), .halt_i(zero1),
    .redirect_i(zero1), .redirect_pc_i(32'h0), .imem_addr_o(addr1),
    .imem_data_i(data1), .instr_valid_o(valid1), .instr_ready_i(ready1),
    .instr_o(instr1), .instr_pc_o(ipc1), .instr_pc_plus4_o(ip41),
    .busy_o(busy1), .accept_count_o(cnt1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a queue of {pc, word} and a PC, stepped once per edge.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc  = 32'h0;
  int          m_st  = c_S_IDLE;
  logic [31:0] m_cnt = 32'h0;
  int          m_sz;
  bit          m_hs;
  bit          m_fe;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc  = 32'h0;
      m_st  = c_S_IDLE;
      m_cnt = 32'h0;
    end else begin
      m_sz = m_q.size();
      m_hs = (m_sz > 0) && ready;
      if (redir) begin
        m_q.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        m_fe = (m_st == c_S_RUN) && en && !halt && ((m_sz < c_DEPTH) || m_hs);
        if (m_hs) begin
          void'(m_q.pop_front());
          m_cnt = m_cnt + 32'd1;
        end
        if (m_fe) begin
          m_q.push_back('{m_pc, mem(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      if (m_st == c_S_IDLE) begin
        if (en) m_st = c_S_RUN;
      end else if (m_st == c_S_RUN) begin
        if (!en) m_st = c_S_IDLE;
        else if (halt && !redir) m_st = c_S_HALT;
      end else begin
        if (!en) m_st = c_S_IDLE;
        else if (!halt) m_st = c_S_RUN;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  logic [31:0] e_instr, e_pc;
  logic        e_valid;
  always @(negedge clk) begin
    e_valid = (m_q.size() > 0);
    e_instr = e_valid ? m_q[0].w  : 32'h0;
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    check("m_valid", {31'b0, valid0}, {31'b0, e_valid});
    check("m_instr", instr0, e_instr);
    check("m_pc",    ipc0,   e_pc);
    check("m_pc4",   ip40,   e_pc + 32'd4);
    check("m_busy",  {31'b0, busy0}, (m_st == c_S_RUN) ? 32'd1 : 32'd0);
    check("m_addr",  addr0,  m_pc);
    check("m_cnt",   cnt0,   m_cnt);
  end

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    halt  = 1'b0;
    redir = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] held_addr;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, valid0}, 32'd0);
    check("rst_instr", instr0, 32'd0);
    check("rst_pc",    ipc0,   32'd0);
    check("rst_pc4",   ip40,   32'd4);
    check("rst_busy",  {31'b0, busy0}, 32'd0);
    check("rst_cnt",   cnt0,   32'd0);
    check("rst_hi_addr", addr1, 32'hFFFF_FFF8);
    #2 rst_n = 1'b1;

    // Streaming with ready held high
    @(negedge clk);
    #1; en = 1'b1; ready = 1'b1; en1 = 1'b1;
    @(negedge clk);
    check("p1_busy",   {31'b0, busy0},  32'd1);
    check("p1_nvalid", {31'b0, valid0}, 32'd0);
    @(negedge clk);
    check("p1_valid0", {31'b0, valid0}, 32'd1);
    check("p1_pc0",    ipc0,   32'h0);
    check("p1_i0",     instr0, 32'd0);
    check("hi_pc0",    ipc1,   32'hFFFF_FFF8);
    check("hi_i0",     instr1, 32'hBFFF_FFFA);
    @(negedge clk);
    check("p1_pc1",    ipc0,   32'h4);
    check("p1_i1",     instr0, 32'd3);
    check("hi_pc1",    ipc1,   32'hFFFF_FFFC);
    check("hi_pc4_1",  ip41,   32'h0000_0000);
    @(negedge clk);
    check("p1_pc2",    ipc0,   32'h8);
    check("p1_i2",     instr0, 32'd6);
    check("hi_pc2",    ipc1,   32'h0000_0000);
    @(negedge clk);
    check("p1_cnt3",   cnt0,   32'd3);
    en1 = 1'b0;

    // Stall from empty: exactly DEPTH words fetched, address frozen
    pulse_reset();
    @(negedge clk);
    #1; en = 1'b1; ready = 1'b0;
    repeat (5) @(negedge clk);
    check("st_addr",   addr0,  32'd4 * c_DEPTH);
    check("st_pc",     ipc0,   32'h0);
    check("st_instr",  instr0, 32'd0);
    #1; ready = 1'b1;
    @(negedge clk);
    check("st_rel1",   ipc0,   32'h4);
    @(negedge clk);
    check("st_rel2",   ipc0,   32'h8);

    // Redirect with a full FIFO
    #1; ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_full", {31'b0, valid0}, 32'd1);
    #1; redir = 1'b1; rpc = 32'h0000_0043;
    @(negedge clk);
    check("rd_nvalid", {31'b0, valid0}, 32'd0);
    check("rd_addr",   addr0,  32'h0000_0040);
    #1; redir = 1'b0;
    @(negedge clk);
    check("rd_instr",  instr0, 32'd48);
    check("rd_pc",     ipc0,   32'h0000_0040);
    #1; ready = 1'b1;
    repeat (3) @(negedge clk);

    // Halt: FIFO drains, PC held, resumes at the held PC
    #1; halt = 1'b1; held_addr = addr0;
    repeat (4) @(negedge clk);
    check("h_valid", {31'b0, valid0}, 32'd0);
    check("h_busy",  {31'b0, busy0},  32'd0);
    check("h_addr",  addr0, held_addr);
    #1; halt = 1'b0;
    repeat (2) @(negedge clk);
    check("h_resume_v",  {31'b0, valid0}, 32'd1);
    check("h_resume_pc", ipc0, held_addr);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      en    = ($urandom_range(0, 15) != 0);
      halt  = ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15))
                                          : ($urandom & 32'h0000_0FFF);
      ready = ($urandom_range(0, 2) != 0);
    end

    // Asynchronous reset with one entry in flight
    @(negedge clk);
    #1; en = 1'b1; halt = 1'b0; redir = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ar_pre_valid", {31'b0, valid0}, 32'd1);
    check("ar_pre_cntnz", {31'b0, (cnt0 != 32'd0)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, valid0}, 32'd0);
    check("ar_instr", instr0, 32'd0);
    check("ar_pc",    ipc0,   32'd0);
    check("ar_pc4",   ip40,   32'd4);
    check("ar_busy",  {31'b0, busy0}, 32'd0);
    check("ar_cnt",   cnt0,   32'd0);
    check("ar_addr",  addr0,  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
